// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: shared constants for the approximate adder pipeline.
//   MODE_EXACT / MODE_APPROX : encoding of the per-beat mode bit
//   DEF_*                    : default parameter values for the core and the pipeline
package approx_adder_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   localparam int unsigned DEF_WIDTH       = 8;
   localparam int unsigned DEF_APPROX_BITS = 2;
   localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/approx_adder_core.sv
// approx_adder_core: purely combinational exact/approximate adder.
//   a, b  : operands (WIDTH bits)
//   mode  : MODE_EXACT or MODE_APPROX
//   sum   : selected result including carry-out (WIDTH+1 bits)
//   err   : |exact - sum| (WIDTH+1 bits)
module approx_adder_core
   import approx_adder_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned APPROX_BITS = DEF_APPROX_BITS
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic [WIDTH:0]   sum,
   output logic [WIDTH:0]   err
);

   logic [WIDTH-1:0] lo_bits;
   logic             cin;
   logic [WIDTH:0]   exact;
   logic [WIDTH:0]   a_hi;
   logic [WIDTH:0]   b_hi;
   logic [WIDTH:0]   hi;
   logic [WIDTH:0]   approx;

   always_comb begin
      lo_bits = '0;
      cin     = 1'b0;
      // Low bits are OR-ed; the carry into the upper part is guessed from the top low bit pair.
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i < int'(APPROX_BITS)) lo_bits[i] = a[i] | b[i];
         if (i == int'(APPROX_BITS) - 1) cin = a[i] & b[i];
      end
      exact  = {1'b0, a} + {1'b0, b};
      a_hi   = {1'b0, a} >> APPROX_BITS;
      b_hi   = {1'b0, b} >> APPROX_BITS;
      hi     = a_hi + b_hi + {{WIDTH{1'b0}}, cin};
      // With APPROX_BITS == 0 this collapses to the exact sum.
      approx = (hi << APPROX_BITS) | {1'b0, lo_bits};
      sum    = (mode == MODE_APPROX) ? approx : exact;
      err    = (exact >= sum) ? (exact - sum) : (sum - exact);
   end

endmodule

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage valid/ready pipeline around approx_adder_core with
// saturating result statistics.
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_ready, a, b, mode : operand beat handshake
//   out_valid/out_ready, sum, err : result handshake
//   stats_clr                : synchronous clear of txn_cnt, mis_cnt, err_acc
//   txn_cnt, mis_cnt, err_acc: delivered results, results with err != 0, summed err
module approx_adder_pipe
   import approx_adder_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned APPROX_BITS = DEF_APPROX_BITS,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH:0]           sum,
   output logic [WIDTH:0]           err,
   input  logic                     stats_clr,
   output logic [CNT_W-1:0]         txn_cnt,
   output logic [CNT_W-1:0]         mis_cnt,
   output logic [CNT_W+WIDTH-1:0]   err_acc
);

   localparam int unsigned AccW = CNT_W + WIDTH;

   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_a_q, s1_a_d;
   logic [WIDTH-1:0]     s1_b_q, s1_b_d;
   logic                 s1_mode_q, s1_mode_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [WIDTH:0]       s2_sum_q, s2_sum_d;
   logic [WIDTH:0]       s2_err_q, s2_err_d;
   logic [CNT_W-1:0]     txn_cnt_q, txn_cnt_d;
   logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;
   logic [AccW-1:0]      err_acc_q, err_acc_d;

   logic                 s1_adv;
   logic                 s2_adv;
   logic                 out_hs;
   logic [WIDTH:0]       core_sum;
   logic [WIDTH:0]       core_err;
   logic [AccW:0]        acc_sum;

   approx_adder_core #(
      .WIDTH       (WIDTH),
      .APPROX_BITS (APPROX_BITS)
   ) u_core (
      .a    (s1_a_q),
      .b    (s1_b_q),
      .mode (s1_mode_q),
      .sum  (core_sum),
      .err  (core_err)
   );

   assign s2_adv    = !s2_valid_q || out_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_hs    = s2_valid_q && out_ready;
   assign out_valid = s2_valid_q;
   assign sum       = s2_sum_q;
   assign err       = s2_err_q;
   assign txn_cnt   = txn_cnt_q;
   assign mis_cnt   = mis_cnt_q;
   assign err_acc   = err_acc_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_err_d   = s2_err_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d    = a;
            s1_b_d    = b;
            s1_mode_d = mode;
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_sum_d = core_sum;
            s2_err_d = core_err;
         end
      end
   end

   always_comb begin
      txn_cnt_d = txn_cnt_q;
      mis_cnt_d = mis_cnt_q;
      err_acc_d = err_acc_q;
      acc_sum   = {1'b0, err_acc_q} + (AccW + 1)'(s2_err_q);
      if (stats_clr) begin
         // Clear beats a coincident handshake.
         txn_cnt_d = '0;
         mis_cnt_d = '0;
         err_acc_d = '0;
      end else if (out_hs) begin
         if (txn_cnt_q != '1) txn_cnt_d = txn_cnt_q + 1'b1;
         if (s2_err_q != '0 && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
         err_acc_d = acc_sum[AccW] ? '1 : acc_sum[AccW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mode_q  <= MODE_EXACT;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_err_q   <= '0;
         txn_cnt_q  <= '0;
         mis_cnt_q  <= '0;
         err_acc_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_err_q   <= s2_err_d;
         txn_cnt_q  <= txn_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
         err_acc_q  <= err_acc_d;
      end
   end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: directed bench for approx_adder_pipe (WIDTH=8, APPROX_BITS=2, CNT_W=16).
module tb_approx_adder_pipe;

   localparam int NV = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [8:0]  sum;
   logic [8:0]  err;
   logic        stats_clr = 1'b0;
   logic [15:0] txn_cnt;
   logic [15:0] mis_cnt;
   logic [23:0] err_acc;

   // Directed vectors with hand-computed results (L = 2: low bits OR-ed, carry guessed from bit 1).
   logic [7:0] va [NV] = '{8'h03, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h0F, 8'hFF, 8'h05, 8'h80, 8'h01};
   logic [7:0] vb [NV] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h03, 8'h0F, 8'hFF, 8'h02, 8'h80, 8'h01};
   logic       vm [NV] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
   logic [8:0] vs [NV] = '{9'h003, 9'h100, 9'h0FF, 9'h004, 9'h007, 9'h01F, 9'h1FF, 9'h007,
                           9'h100, 9'h001};
   logic [8:0] ve [NV] = '{9'h1, 9'h0, 9'h1, 9'h0, 9'h1, 9'h1, 9'h1, 9'h0, 9'h0, 9'h1};

   int n_cmp = 0;
   int n_bad = 0;
   int expq[$];

   logic [15:0] m_txn = '0;
   logic [15:0] m_mis = '0;
   logic [23:0] m_acc = '0;

   approx_adder_pipe #(
      .WIDTH       (8),
      .APPROX_BITS (2),
      .CNT_W       (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .err       (err),
      .stats_clr (stats_clr),
      .txn_cnt   (txn_cnt),
      .mis_cnt   (mis_cnt),
      .err_acc   (err_acc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, score any output handshake.
   task automatic cyc(input logic iv, input logic orr, input logic clr, input int vi,
                      output logic acc);
      logic [24:0] t;
      int          hv;
      @(negedge clk);
      in_valid  = iv;
      out_ready = orr;
      stats_clr = clr;
      if (vi >= 0) begin
         a    = va[vi];
         b    = vb[vi];
         mode = vm[vi];
      end
      #1;
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            check_eq("spurious_out", out_valid, 1'b0);
         end else begin
            hv = expq.pop_front();
            check_eq($sformatf("sum[%0d]", hv), sum, vs[hv]);
            check_eq($sformatf("err[%0d]", hv), err, ve[hv]);
            if (!clr) begin
               if (m_txn != 16'hFFFF) m_txn++;
               if (ve[hv] != 0 && m_mis != 16'hFFFF) m_mis++;
               t = {1'b0, m_acc} + 25'(ve[hv]);
               m_acc = t[24] ? 24'hFFFFFF : t[23:0];
            end
         end
      end
      if (clr) begin
         m_txn = '0;
         m_mis = '0;
         m_acc = '0;
      end
      acc = iv && in_ready;
      if (acc) expq.push_back(vi);
   endtask

   task automatic chk_stats(input string tag);
      @(posedge clk);
      #1;
      check_eq({tag, "_txn"}, txn_cnt, m_txn);
      check_eq({tag, "_mis"}, mis_cnt, m_mis);
      check_eq({tag, "_acc"}, err_acc, m_acc);
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int k = 0; k < 30 && expq.size() > 0; k++) cyc(1'b0, 1'b1, 1'b0, -1, acc);
      check_eq({tag, "_drain"}, expq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   vi;
      int   n_acc;
      logic [4:0] pat;

      // Reset state
      #12;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_sum", sum, 9'h0);
      check_eq("rst_err", err, 9'h0);
      check_eq("rst_txn", txn_cnt, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single approximate beat: latency and statistics
      cyc(1'b1, 1'b1, 1'b0, 0, acc);
      check_eq("lat_accept", acc, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, -1, acc);
      check_eq("lat_not_yet", out_valid, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, -1, acc);
      check_eq("lat_valid", out_valid, 1'b1);
      chk_stats("one");
      check_eq("one_mis_const", mis_cnt, 16'd1);
      check_eq("one_acc_const", err_acc, 24'd1);

      // Back-to-back streaming, mode changing per beat
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, i, acc);
         check_eq($sformatf("stream_acc[%0d]", i), acc, 1'b1);
      end
      drain("stream");

      // Stall: out_ready low for 5 cycles under continuous in_valid
      vi = 4;
      n_acc = 0;
      for (int c = 0; c < 5; c++) begin
         cyc(1'b1, 1'b0, 1'b0, vi, acc);
         if (acc) begin
            vi++;
            n_acc++;
         end
         if (c >= 2) begin
            check_eq($sformatf("stall_in_ready[%0d]", c), in_ready, 1'b0);
            check_eq($sformatf("stall_sum[%0d]", c), sum, 9'h007);
         end
      end
      check_eq("stall_buffered", n_acc, 2);
      pat = 5'b11011;
      for (int c = 0; c < 40 && vi < NV; c++) begin
         cyc(1'b1, pat[c % 5], 1'b0, vi, acc);
         if (acc) vi++;
      end
      drain("stall");
      chk_stats("all");
      check_eq("all_txn_const", txn_cnt, 16'd10);
      check_eq("all_mis_const", mis_cnt, 16'd6);
      check_eq("all_acc_const", err_acc, 24'd6);

      // Saturation of txn_cnt
      @(negedge clk);
      force dut.txn_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.txn_cnt_q;
      m_txn = 16'hFFFE;
      check_eq("sat_preset", txn_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, i, acc);
      drain("sat");
      chk_stats("sat");
      check_eq("sat_const", txn_cnt, 16'hFFFF);

      // Clear coincident with a handshake
      cyc(1'b1, 1'b1, 1'b0, 4, acc);
      cyc(1'b0, 1'b1, 1'b0, -1, acc);
      cyc(1'b0, 1'b1, 1'b1, -1, acc);
      chk_stats("clr");
      check_eq("clr_txn_const", txn_cnt, 16'd0);
      check_eq("clr_acc_const", err_acc, 24'd0);
      check_eq("clr_consumed", out_valid, 1'b0);

      // Reset with two beats in flight
      cyc(1'b1, 1'b1, 1'b0, 0, acc);
      drain("pre_rst");
      cyc(1'b1, 1'b0, 1'b0, 4, acc);
      cyc(1'b1, 1'b0, 1'b0, 5, acc);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("mrst_out_valid", out_valid, 1'b0);
      check_eq("mrst_in_ready", in_ready, 1'b1);
      check_eq("mrst_txn", txn_cnt, 16'd0);
      check_eq("mrst_mis", mis_cnt, 16'd0);
      check_eq("mrst_acc", err_acc, 24'd0);
      check_eq("mrst_sum", sum, 9'h0);
      expq.delete();
      m_txn = '0;
      m_mis = '0;
      m_acc = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc(1'b0, 1'b1, 1'b0, -1, acc);
         check_eq($sformatf("post_rst_valid[%0d]", c), out_valid, 1'b0);
      end
      chk_stats("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/approx_adder_pipe.md
APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (2..32).
REQ-002 SHALL have parameter APPROX_BITS, default 2, approximated low-bit count (0..WIDTH).
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand beat valid.
REQ-007 in_ready  out  1  block accepts beat.
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 mode  in  1  0 = exact, 1 = approximate; sampled with the beat.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 sum  out  WIDTH+1  result including carry-out.
REQ-013 err  out  WIDTH+1  |exact - sum| for this beat.
REQ-014 stats_clr  in  1  synchronous clear of statistics.
REQ-015 txn_cnt, mis_cnt  out  CNT_W each  accepted results; results with err != 0.
REQ-016 err_acc  out  CNT_W+WIDTH  accumulated err.

Function
REQ-017 Exact sum SHALL be a + b, zero-extended to WIDTH+1.
REQ-018 Approximate sum, L = APPROX_BITS: bits [L-1:0] = a[L-1:0] | b[L-1:0]; upper = a[W-1:L] + b[W-1:L] + (a[L-1] & b[L-1]); for L = 0, approximate equals exact.
REQ-019 Stage 1 SHALL register a, b, mode on in_valid & in_ready; stage 2 SHALL register sum and err; latency 2 cycles from accept to out_valid with no stall.
REQ-020 Stage 2 advances when !s2_valid | out_ready; stage 1 advances when !s1_valid | stage-2 advance; in_ready = stage-1 advance (combinational from out_ready).
REQ-021 Throughput SHALL be one beat per cycle while out_ready stays high; no beat lost or duplicated under any stall pattern.
REQ-022 sum, err SHALL stay stable while out_valid & !out_ready.
REQ-023 On out_valid & out_ready: txn_cnt += 1; mis_cnt += 1 if err != 0; err_acc += err; each saturates at all-ones, no wrap.
REQ-024 stats_clr SHALL zero all three statistics next cycle; clear coincident with handshake SHALL win (result 0, beat not counted); pipeline data unaffected.
REQ-025 mode SHALL travel with its beat; changing mode mid-stream SHALL affect only newly accepted beats.

Reset
REQ-026 rst_n low SHALL asynchronously clear s1_valid, s2_valid, out_valid, sum, err, txn_cnt, mis_cnt, err_acc to 0.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty); beats in flight at reset SHALL be discarded.
REQ-028 Reset release SHALL be synchronised externally; block needs no clocks in reset to settle.

Structure
REQ-029 Package approx_adder_pkg SHALL hold mode encoding (MODE_EXACT = 0, MODE_APPROX = 1) and default WIDTH/APPROX_BITS/CNT_W constants.
REQ-030 One combinational sub-module approx_adder_core (a, b, mode -> sum, err) SHALL hold REQ-017/018 arithmetic; pipeline, handshake and statistics stay in approx_adder_pipe.

Verification (WIDTH=8, APPROX_BITS=2, CNT_W=16)
REQ-031 mode=1, a=0x03, b=0x01 -> two cycles later sum=0x003, err=0x001; after handshake mis_cnt=1, err_acc=1.
REQ-032 a=0xFF, b=0x01: mode=0 -> sum=0x100, err=0; mode=1 -> sum=0x0FF, err=1.
REQ-033 out_ready low 5 cycles under continuous in_valid -> in_ready drops after 2 beats buffered, sum held stable, all beats later delivered in order.
REQ-034 Force txn_cnt to 0xFFFE, send 3 beats -> txn_cnt sticks at 0xFFFF; stats_clr with a concurrent handshake -> all stats 0.
REQ-035 rst_n asserted mid-stream with 2 beats in flight -> out_valid=0 immediately, stats 0, in_ready=1; no stale beat emitted after release.
